// File: rtl/branch_flow_pkg.sv
// Shared types and constants for the branch flow controller.
// State encoding and control-transfer opcode field values (inst[6:2]).
package branch_flow_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitEx   = 2'd1,
        StRedirect = 2'd2
    } br_state_t;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

endpackage

// File: rtl/br_opcode_decode.sv
// Combinational detector for control-transfer instructions sitting in IF.
module br_opcode_decode
    import branch_flow_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH    = 32,
    parameter int unsigned WIDTH_CONTROL_LENGTH = 5
) (
    input  logic [WIDTH_DATA_LENGTH-1:0] if_inst,
    input  logic                         if_valid,
    output logic                         br_det
);

    logic [WIDTH_CONTROL_LENGTH-1:0] opcode;
    logic                            unused_inst_bits;

    assign opcode = if_inst[2 +: WIDTH_CONTROL_LENGTH];
    // Only the opcode field matters; the rest of the word is deliberately ignored.
    assign unused_inst_bits = ^{if_inst[WIDTH_DATA_LENGTH-1:2+WIDTH_CONTROL_LENGTH],
                                if_inst[1:0]};

    always_comb begin
        br_det = 1'b0;
        if (if_valid) begin
            br_det = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
        end
    end

endmodule

// File: rtl/branch_flow_ctrl.sv
// Fetch stall / redirect sequencer for branches travelling IF -> EX, with watchdog.
// Optional per-branch statistics counters enabled by BRANCH_FLOW_STATS_EN.
module branch_flow_ctrl
    import branch_flow_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH    = 32,
    parameter int unsigned WIDTH_CONTROL_LENGTH = 5,
    parameter int unsigned TIMEOUT_CYCLES       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] if_inst,
    input  logic                         if_valid,
    input  logic                         ex_br_resolved,
    input  logic                         ex_br_taken,
    input  logic [WIDTH_DATA_LENGTH-1:0] ex_br_target,
    output logic                         pc_stall,
    output logic                         id_bubble,
    output logic                         if_id_flush,
    output logic                         pc_sel,
    output logic [WIDTH_DATA_LENGTH-1:0] pc_target,
    output logic                         br_busy,
    output logic                         br_timeout,
    output logic [31:0]                  br_count,
    output logic [31:0]                  br_taken_count
);

    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    br_state_t                    state_q;
    logic [7:0]                   wait_cnt_q;
    logic [WIDTH_DATA_LENGTH-1:0] pc_target_q;
    logic                         br_timeout_q;
    logic                         br_det;
    logic                         taken_res;

    br_opcode_decode #(
        .WIDTH_DATA_LENGTH   (WIDTH_DATA_LENGTH),
        .WIDTH_CONTROL_LENGTH(WIDTH_CONTROL_LENGTH)
    ) u_decode (
        .if_inst (if_inst),
        .if_valid(if_valid),
        .br_det  (br_det)
    );

    assign taken_res = (state_q == StWaitEx) && ex_br_resolved && ex_br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 8'd0;
            pc_target_q  <= '0;
            br_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (br_det) begin
                        state_q    <= StWaitEx;
                        wait_cnt_q <= 8'd0;
                    end
                end
                StWaitEx: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    // A resolution in the final watchdog cycle still wins.
                    if (ex_br_resolved) begin
                        if (ex_br_taken) begin
                            pc_target_q <= ex_br_target;
                            state_q     <= StRedirect;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (wait_cnt_q == WaitLast) begin
                        br_timeout_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                StRedirect: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        id_bubble   = 1'b0;
        if_id_flush = 1'b0;
        pc_sel      = 1'b0;
        br_busy     = 1'b0;
        unique case (state_q)
            StIdle:   pc_stall = br_det;
            StWaitEx: begin
                pc_stall  = 1'b1;
                id_bubble = 1'b1;
                br_busy   = 1'b1;
            end
            StRedirect: begin
                pc_sel      = 1'b1;
                if_id_flush = 1'b1;
                br_busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_target  = pc_target_q;
    assign br_timeout = br_timeout_q;

`ifdef BRANCH_FLOW_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] br_taken_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q       <= 32'd0;
            br_taken_count_q <= 32'd0;
        end else begin
            if ((state_q == StIdle) && br_det) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (taken_res) begin
                br_taken_count_q <= br_taken_count_q + 32'd1;
            end
        end
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;
`else
    logic unused_taken_res;

    assign unused_taken_res = taken_res;
    assign br_count         = 32'd0;
    assign br_taken_count   = 32'd0;
`endif

endmodule

// File: doc/branch_flow_ctrl.md
Name: branch_flow_ctrl

Overview:
- Pipeline control-flow sequencer for the 5-stage RISC-V core.
- Spots control-transfer instructions in IF (opcode[6:2] = BRANCH 11000, JAL 11011, JALR 11001) and stalls the PC while the branch travels to EX.
- On EX resolution, either releases fetch (not taken) or performs a one-cycle redirect with IF/ID flush (taken).
- A watchdog flags a branch that never resolves.

Parameters:
- WIDTH_DATA_LENGTH, 32: instruction and PC width.
- WIDTH_CONTROL_LENGTH, 5: opcode field width, bits [6:2].
- TIMEOUT_CYCLES, 8: maximum WAIT_EX cycles before the watchdog fires; legal range 2..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_inst  input  WIDTH_DATA_LENGTH  instruction currently in IF.
- if_valid  input  1  if_inst is a real fetched instruction.
- ex_br_resolved  input  1  branch in EX resolved this cycle (single-cycle pulse).
- ex_br_taken  input  1  qualified by ex_br_resolved; 1 = redirect required.
- ex_br_target  input  WIDTH_DATA_LENGTH  target PC, qualified by ex_br_resolved & ex_br_taken.
- pc_stall  output  1  hold PC and the IF/ID register.
- id_bubble  output  1  inject NOP into ID/EX.
- if_id_flush  output  1  squash IF/ID contents.
- pc_sel  output  1  1 = PC loads pc_target.
- pc_target  output  WIDTH_DATA_LENGTH  redirect PC.
- br_busy  output  1  controller is not in IDLE.
- br_timeout  output  1  sticky watchdog flag.
- br_count  output  32  branches detected (BR_STATS_EN only).
- br_taken_count  output  32  taken resolutions (BR_STATS_EN only).

Behaviour:
- Detection (combinational): br_det = if_valid & (if_inst[6:2] ∈ {11000, 11011, 11001}). All other opcodes, including 11100, give 0.
- FSM states: IDLE, WAIT_EX, REDIRECT. State is registered; the state register and every other register are cleared by rst asynchronously.
- Reset values: state = IDLE; wait_cnt, pc_target, br_timeout, and both counters = 0. All decoded outputs evaluate low in IDLE with br_det = 0.
- IDLE:
  - pc_stall = br_det (Mealy), so the instruction after the branch is never fetched.
  - id_bubble = 0.
  - If br_det: next state WAIT_EX, wait_cnt <= 0.
  - ex_br_resolved is ignored in IDLE.
- WAIT_EX:
  - pc_stall = 1, id_bubble = 1, br_busy = 1; wait_cnt increments each cycle.
  - If ex_br_resolved & ex_br_taken: pc_target <= ex_br_target; next state REDIRECT.
  - If ex_br_resolved & !ex_br_taken: next state IDLE. Fetch resumes the following cycle with no flush.
  - Else if wait_cnt == TIMEOUT_CYCLES-1: br_timeout <= 1; next state IDLE; no redirect.
  - Resolution takes priority over timeout when both occur in the same cycle.
  - br_det is ignored in WAIT_EX (IF is frozen).
- REDIRECT (exactly one cycle):
  - pc_sel = 1, if_id_flush = 1, pc_stall = 0, id_bubble = 0, br_busy = 1.
  - pc_target holds the latched value.
  - br_det is ignored because the IF instruction is wrong-path.
  - Next state IDLE.
- pc_target holds its value outside REDIRECT and changes only on a taken resolution.
- br_timeout is cleared only by rst.
- Latency:
  - Taken branch: fetch frozen from the detect cycle through the resolve cycle; redirect the cycle after resolve.
  - Not taken: fetch resumes the cycle after resolve.
- Back-to-back branches: a branch arriving in IF on the cycle after IDLE is re-entered is detected normally.
- Reset mid-operation: immediate return to IDLE. Any pending redirect is dropped, and pc_sel and pc_stall drop asynchronously.

Optional Feature:
- BRANCH_FLOW_STATS_EN defined:
  - br_count increments on every IDLE-state br_det.
  - br_taken_count increments on every taken resolution in WAIT_EX.
  - Both are 32-bit wrapping counters, reset to 0.
- Undefined: br_count and br_taken_count ports remain present and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package branch_flow_pkg:
  - State encoding: IDLE = 2'd0, WAIT_EX = 2'd1, REDIRECT = 2'd2.
  - Opcode constants OPC_BRANCH = 5'b11000, OPC_JAL = 5'b11011, OPC_JALR = 5'b11001.
- One sub-module, br_opcode_decode: purely combinational; if_inst, if_valid -> br_det.
- FSM, watchdog, target latch and stats stay in branch_flow_ctrl.

Test Plan:
- Not taken: BEQ (if_inst[6:0] = 7'b1100011), if_valid = 1 at cycle 0 -> pc_stall = 1 cycles 0-3. ex_br_resolved = 1, taken = 0 at cycle 3 -> cycle 4: IDLE, pc_stall = 0, pc_sel = 0, if_id_flush = 0.
- Taken JAL: opcode 1101111 detected. Resolve taken at cycle 2 with target 32'h0000_0400 -> cycle 3: pc_sel = 1, if_id_flush = 1, pc_target = 32'h400, pc_stall = 0. Cycle 4: IDLE.
- Non-branch filtering: ADDI (0010011), LOAD (0000011), SYSTEM (1110011), and a BEQ with if_valid = 0 -> pc_stall never asserts; br_busy stays 0.
- Watchdog with TIMEOUT_CYCLES = 8: JALR detected, no resolve -> br_timeout = 1 after 8 WAIT_EX cycles, state IDLE. A later branch still works and br_timeout stays 1.
- Async reset: rst pulsed mid-cycle while in WAIT_EX -> pc_stall and br_busy drop before the next clk edge. Next rising edge with a branch in IF -> re-detected from IDLE.
- With BRANCH_FLOW_STATS_EN: 3 branches, 2 taken -> br_count = 3, br_taken_count = 2. Without the macro, both outputs read 0.
